// File: rtl/spi_stream_dma_if.sv
// Port bundle for spi_stream_dma: start/status, SPI RX stream and AHB-Lite master.
// master is the DMA's own view; slave is the view of whatever sits around it.
interface spi_stream_dma_if #(
    parameter int W_COUNT = 16
);
    logic               cfg_start;
    logic [31:0]        cfg_addr;
    logic [W_COUNT-1:0] cfg_count;
    logic               busy;
    logic               done;
    logic               err;
    logic [31:0]        s_data;
    logic               s_valid;
    logic               s_ready;
    logic [31:0]        ahbm_haddr;
    logic [1:0]         ahbm_htrans;
    logic               ahbm_hwrite;
    logic [2:0]         ahbm_hsize;
    logic [31:0]        ahbm_hwdata;
    logic               ahbm_hready;
    logic               ahbm_hresp;

    modport master (
        input  cfg_start, cfg_addr, cfg_count, s_data, s_valid, ahbm_hready, ahbm_hresp,
        output busy, done, err, s_ready,
               ahbm_haddr, ahbm_htrans, ahbm_hwrite, ahbm_hsize, ahbm_hwdata
    );

    modport slave (
        output cfg_start, cfg_addr, cfg_count, s_data, s_valid, ahbm_hready, ahbm_hresp,
        input  busy, done, err, s_ready,
               ahbm_haddr, ahbm_htrans, ahbm_hwrite, ahbm_hsize, ahbm_hwdata
    );
endinterface

// File: rtl/spi_stream_dma.sv
// Moves cfg_count 32-bit words from the SPI RX stream to an incrementing AHB-Lite
// address, one NONSEQ single write per word, address/data phases overlapped.
module spi_stream_dma #(
    parameter int W_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    spi_stream_dma_if.master bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    logic [0:0]         state;
    logic [31:0]        addr;
    logic [31:0]        beat_data;
    logic [W_COUNT-1:0] rem_issue;
    logic [W_COUNT-1:0] rem_data;
    logic               dp_active;
    logic               run;
    logic               pop;
    logic               err_first;
    logic               err_second;
    logic               ap_done;

    assign run        = (state == ST_RUN);
    assign bus.busy   = run;
    // An error response in flight blocks further pops so nothing is lost upstream.
    assign bus.s_ready = run && !rst && bus.ahbm_hready && !bus.ahbm_hresp &&
                         (rem_issue != '0);
    assign pop        = bus.s_valid && bus.s_ready;
    assign err_first  = run && bus.ahbm_hresp && !bus.ahbm_hready;
    assign err_second = run && bus.ahbm_hresp && bus.ahbm_hready;
    assign ap_done    = bus.ahbm_hready && (bus.ahbm_htrans == HT_NONSEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            addr            <= '0;
            beat_data       <= '0;
            rem_issue       <= '0;
            rem_data        <= '0;
            dp_active       <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            bus.ahbm_haddr  <= '0;
            bus.ahbm_htrans <= HT_IDLE;
            bus.ahbm_hwrite <= 1'b0;
            bus.ahbm_hsize  <= 3'b010;
            bus.ahbm_hwdata <= '0;
        end else begin
            bus.done <= 1'b0;
            if (!run) begin
                if (bus.cfg_start) begin
                    addr      <= bus.cfg_addr & ~32'd3;
                    rem_issue <= bus.cfg_count;
                    rem_data  <= bus.cfg_count;
                    bus.err   <= 1'b0;
                    if (bus.cfg_count == '0) bus.done <= 1'b1;
                    else                     state    <= ST_RUN;
                end
            end else if (err_second) begin
                // Abort: anything captured but not yet written is dropped.
                state           <= ST_IDLE;
                bus.err         <= 1'b1;
                bus.done        <= 1'b1;
                bus.ahbm_htrans <= HT_IDLE;
                bus.ahbm_hwrite <= 1'b0;
                bus.ahbm_hwdata <= '0;
                dp_active       <= 1'b0;
            end else if (err_first) begin
                bus.ahbm_htrans <= HT_IDLE;
                bus.ahbm_hwrite <= 1'b0;
            end else if (bus.ahbm_hready) begin
                if (pop) begin
                    bus.ahbm_htrans <= HT_NONSEQ;
                    bus.ahbm_haddr  <= addr;
                    bus.ahbm_hwrite <= 1'b1;
                    addr            <= addr + 32'd4;
                    rem_issue       <= rem_issue - W_COUNT'(1);
                    beat_data       <= bus.s_data;
                end else begin
                    bus.ahbm_htrans <= HT_IDLE;
                    bus.ahbm_hwrite <= 1'b0;
                end
                if (ap_done) begin
                    dp_active       <= 1'b1;
                    bus.ahbm_hwdata <= beat_data;
                end else begin
                    dp_active       <= 1'b0;
                    bus.ahbm_hwdata <= '0;
                end
                if (dp_active) begin
                    rem_data <= rem_data - W_COUNT'(1);
                    if (rem_data == W_COUNT'(1)) begin
                        state    <= ST_IDLE;
                        bus.done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_stream_dma.sv
// Bench for spi_stream_dma: random stream source, AHB slave-side transaction
// monitor, and a scoreboard of expected (address, word) writes.
`timescale 1ns/1ps
module tb_spi_stream_dma;
    localparam int W_COUNT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_stream_dma_if #(.W_COUNT(W_COUNT)) bus ();
    spi_stream_dma #(.W_COUNT(W_COUNT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state (written only by the monitor)
    logic [31:0] popped[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int          wr_cyc[$];
    int          ap_cyc[$];
    int naddr = 0, dones = 0, done_cyc = 0;
    int stall_bad = 0, bad_trans = 0, bad_hwdata = 0, rdy_after = 0, idle_busy = 0;
    bit fire = 1'b0, dp_v = 1'b0, prev_stall = 1'b0;
    logic [31:0] dp_a, p_a, p_d;
    logic [1:0]  p_t;

    // Test-side knobs and snapshots
    int vmode = 0;
    int lim = 32'h3fffffff;
    int st_cyc = 0;
    int sb_w0, sb_p0, n0, d0, sb0, bt0, bh0, r0, ib0;

    always @(negedge clk) begin
        if (rst) begin
            fire       = 1'b0;
            dp_v       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.s_ready && popped.size() >= lim) rdy_after++;
            fire = bus.s_valid && bus.s_ready;
            if (fire) popped.push_back(bus.s_data);
            if (!dp_v && bus.ahbm_hwdata !== 32'd0) bad_hwdata++;
            if (dp_v && bus.ahbm_hready && !bus.ahbm_hresp) begin
                wr_a.push_back(dp_a);
                wr_d.push_back(bus.ahbm_hwdata);
                wr_cyc.push_back(cyc);
            end
            if (prev_stall && !bus.ahbm_hresp &&
                (bus.ahbm_htrans !== p_t || bus.ahbm_haddr !== p_a || bus.ahbm_hwdata !== p_d))
                stall_bad++;
            if (bus.ahbm_htrans[0] !== 1'b0) bad_trans++;
            if (bus.busy && bus.ahbm_htrans == 2'b00) idle_busy++;
            if (bus.done) begin dones++; done_cyc = cyc; end
            if (bus.ahbm_hready) begin
                if (bus.ahbm_htrans == 2'b10) begin naddr++; ap_cyc.push_back(cyc); end
                dp_v = (bus.ahbm_htrans == 2'b10);
                dp_a = bus.ahbm_haddr;
            end
            prev_stall = !bus.ahbm_hready;
            p_t = bus.ahbm_htrans;
            p_a = bus.ahbm_haddr;
            p_d = bus.ahbm_hwdata;
        end
    end

    // Stream source: a fresh random word after each accepted one.
    initial begin
        int ph;
        ph = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            if (fire) bus.s_data = $urandom;
            case (vmode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (ph == 0);
                default: bus.s_valid = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Expected writes: i-th write goes to aligned base + 4*i and carries the i-th popped word.
    function automatic int sb_errors(logic [31:0] base);
        int e;
        int k;
        logic [31:0] a;
        e = 0;
        a = base & ~32'd3;
        for (int i = sb_w0; i < wr_a.size(); i++) begin
            k = i - sb_w0;
            if (wr_a[i] !== a + 32'(4 * k)) e++;
            if ((sb_p0 + k) >= popped.size() || wr_d[i] !== popped[sb_p0 + k]) e++;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        sb_w0 = wr_a.size();
        sb_p0 = popped.size();
        n0 = naddr; d0 = dones; sb0 = stall_bad; bt0 = bad_trans;
        bh0 = bad_hwdata; r0 = rdy_after; ib0 = idle_busy;
    endtask

    task automatic start(logic [31:0] a, int n);
        bus.cfg_addr  = a;
        bus.cfg_count = W_COUNT'(n);
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic wait_done(int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (dones > d0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_ap(logic [31:0] a, int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.ahbm_htrans == 2'b10 && bus.ahbm_haddr == a) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vmode = 0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%0b exp=0", bus.s_ready); end
        checks++; if (bus.ahbm_htrans !== 2'b00) begin errors++; $display("FAIL reset_htrans got=%0b exp=00", bus.ahbm_htrans); end
        checks++; if (bus.ahbm_haddr !== 32'd0) begin errors++; $display("FAIL reset_haddr got=%h exp=0", bus.ahbm_haddr); end
        checks++; if (bus.ahbm_hwdata !== 32'd0) begin errors++; $display("FAIL reset_hwdata got=%h exp=0", bus.ahbm_hwdata); end
        checks++; if (bus.ahbm_hwrite !== 1'b0) begin errors++; $display("FAIL reset_hwrite got=%0b exp=0", bus.ahbm_hwrite); end
        checks++; if (bus.ahbm_hsize !== 3'b010) begin errors++; $display("FAIL reset_hsize got=%b exp=010", bus.ahbm_hsize); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        snap();
        start(32'h2000_0003, 4);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", bus.busy); end
        wait_done(50, ok);
        tick(); tick();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got=%0b exp=1", ok); end
        checks++; if (wr_a.size() - sb_w0 !== 4) begin errors++; $display("FAIL basic_writes got=%0d exp=4", wr_a.size() - sb_w0); end
        if (wr_a.size() > sb_w0) begin
            checks++; if (wr_a[sb_w0] !== 32'h2000_0000) begin errors++; $display("FAIL basic_addr0 got=%h exp=20000000", wr_a[sb_w0]); end
        end
        checks++; if (sb_errors(32'h2000_0003) !== 0) begin errors++; $display("FAIL basic_scoreboard got=%0d exp=0", sb_errors(32'h2000_0003)); end
        checks++; if (naddr - n0 !== 4) begin errors++; $display("FAIL basic_nonseq got=%0d exp=4", naddr - n0); end
        if (naddr - n0 >= 4) begin
            checks++; if (ap_cyc[n0 + 3] - ap_cyc[n0] !== 3) begin errors++; $display("FAIL basic_b2b got=%0d exp=3", ap_cyc[n0 + 3] - ap_cyc[n0]); end
        end
        if (wr_cyc.size() > 0) begin
            checks++; if (done_cyc !== wr_cyc[$] + 1) begin errors++; $display("FAIL basic_done_lat got=%0d exp=%0d", done_cyc, wr_cyc[$] + 1); end
        end
        checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL basic_done_cnt got=%0d exp=1", dones - d0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%0b exp=0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err got=%0b exp=0", bus.err); end
        checks++; if (bad_hwdata - bh0 !== 0) begin errors++; $display("FAIL basic_hwdata_idle got=%0d exp=0", bad_hwdata - bh0); end
    endtask

    task automatic test_stall();
        bit ok, found;
        logic [31:0] base;
        base = $urandom;
        base[1:0] = 2'b00;
        base[31] = 1'b0;
        snap();
        start(base, 3);
        wait_ap(base + 32'd4, 20, found);
        bus.ahbm_hready = 1'b0;
        tick();
        checks++; if (bus.ahbm_htrans !== 2'b10 || bus.ahbm_haddr !== base + 32'd4) begin errors++; $display("FAIL stall_hold got=%b/%h exp=10/%h", bus.ahbm_htrans, bus.ahbm_haddr, base + 32'd4); end
        tick();
        bus.ahbm_hready = 1'b1;
        wait_done(50, ok);
        tick(); tick();
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_find got=%0b exp=1", found); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout got=%0b exp=1", ok); end
        checks++; if (stall_bad - sb0 !== 0) begin errors++; $display("FAIL stall_stable got=%0d exp=0", stall_bad - sb0); end
        checks++; if (wr_a.size() - sb_w0 !== 3) begin errors++; $display("FAIL stall_writes got=%0d exp=3", wr_a.size() - sb_w0); end
        checks++; if (popped.size() - sb_p0 !== 3) begin errors++; $display("FAIL stall_pops got=%0d exp=3", popped.size() - sb_p0); end
        checks++; if (sb_errors(base) !== 0) begin errors++; $display("FAIL stall_scoreboard got=%0d exp=0", sb_errors(base)); end
    endtask

    task automatic test_gapped();
        bit ok;
        logic [31:0] base;
        base = 32'h1000_0100;
        vmode = 1;
        snap();
        lim = popped.size() + 2;
        start(base, 2);
        wait_done(60, ok);
        tick(); tick();
        lim = 32'h3fffffff;
        vmode = 0;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL gap_timeout got=%0b exp=1", ok); end
        checks++; if (wr_a.size() - sb_w0 !== 2) begin errors++; $display("FAIL gap_writes got=%0d exp=2", wr_a.size() - sb_w0); end
        checks++; if (popped.size() - sb_p0 !== 2) begin errors++; $display("FAIL gap_pops got=%0d exp=2", popped.size() - sb_p0); end
        checks++; if (rdy_after - r0 !== 0) begin errors++; $display("FAIL gap_ready_after got=%0d exp=0", rdy_after - r0); end
        checks++; if (idle_busy - ib0 < 3) begin errors++; $display("FAIL gap_idle got=%0d exp>=3", idle_busy - ib0); end
        checks++; if (sb_errors(base) !== 0) begin errors++; $display("FAIL gap_scoreboard got=%0d exp=0", sb_errors(base)); end
    endtask

    task automatic test_error();
        bit ok, found;
        int pe;
        logic [31:0] base;
        base = 32'h3000_0040;
        snap();
        start(base, 5);
        wait_ap(base + 32'd4, 20, found);
        tick();
        pe = popped.size();
        bus.ahbm_hready = 1'b0;
        bus.ahbm_hresp  = 1'b1;
        tick();
        checks++; if (bus.ahbm_htrans !== 2'b00) begin errors++; $display("FAIL err_cancel got=%b exp=00", bus.ahbm_htrans); end
        bus.ahbm_hready = 1'b1;
        tick();
        bus.ahbm_hresp = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL err_done got=%0b exp=1", bus.done); end
        wait_done(5, ok);
        tick(); tick(); tick();
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL err_find got=%0b exp=1", found); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp=1", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_busy got=%0b exp=0", bus.busy); end
        checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL err_done_cnt got=%0d exp=1", dones - d0); end
        checks++; if (popped.size() - pe > 2) begin errors++; $display("FAIL err_pops got=%0d exp<=2", popped.size() - pe); end
        checks++; if (wr_a.size() - sb_w0 !== 1) begin errors++; $display("FAIL err_writes got=%0d exp=1", wr_a.size() - sb_w0); end
        checks++; if (sb_errors(base) !== 0) begin errors++; $display("FAIL err_scoreboard got=%0d exp=0", sb_errors(base)); end
    endtask

    task automatic test_zero_and_wrap();
        bit ok;
        snap();
        lim = popped.size();
        start(32'h4000_0000, 0);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got=%0b exp=1", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL zero_err_clear got=%0b exp=0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%0b exp=0", bus.busy); end
        tick(); tick(); tick();
        lim = 32'h3fffffff;
        checks++; if (done_cyc !== st_cyc) begin errors++; $display("FAIL zero_done_cyc got=%0d exp=%0d", done_cyc, st_cyc); end
        checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL zero_done_cnt got=%0d exp=1", dones - d0); end
        checks++; if (naddr - n0 !== 0) begin errors++; $display("FAIL zero_nonseq got=%0d exp=0", naddr - n0); end
        checks++; if (rdy_after - r0 !== 0) begin errors++; $display("FAIL zero_ready got=%0d exp=0", rdy_after - r0); end
        snap();
        start(32'hFFFF_FFFC, 2);
        wait_done(40, ok);
        tick(); tick();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_timeout got=%0b exp=1", ok); end
        checks++; if (wr_a.size() - sb_w0 !== 2) begin errors++; $display("FAIL wrap_writes got=%0d exp=2", wr_a.size() - sb_w0); end
        if (wr_a.size() - sb_w0 >= 2) begin
            checks++; if (wr_a[sb_w0 + 1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", wr_a[sb_w0 + 1]); end
        end
        checks++; if (sb_errors(32'hFFFF_FFFC) !== 0) begin errors++; $display("FAIL wrap_scoreboard got=%0d exp=0", sb_errors(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        snap();
        start(32'h5000_0000, 8);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.ahbm_htrans !== 2'b00) begin errors++; $display("FAIL rstmid_htrans got=%b exp=00", bus.ahbm_htrans); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", bus.busy); end
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (dones - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dones - d0); end
        snap();
        start(32'h5000_1000, 3);
        wait_done(40, ok);
        tick(); tick();
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_restart got=%0b exp=1", ok); end
        checks++; if (wr_a.size() - sb_w0 !== 3) begin errors++; $display("FAIL rstmid_writes got=%0d exp=3", wr_a.size() - sb_w0); end
        checks++; if (sb_errors(32'h5000_1000) !== 0) begin errors++; $display("FAIL rstmid_scoreboard got=%0d exp=0", sb_errors(32'h5000_1000)); end
    endtask

    task automatic test_random();
        int n;
        bit ok;
        logic [31:0] base;
        vmode = 2;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 12);
            base = $urandom;
            snap();
            start(base, n);
            ok = 1'b0;
            for (int c = 0; c < 400; c++) begin
                bus.ahbm_hready = ($urandom_range(0, 3) != 0);
                tick();
                if (dones > d0) begin ok = 1'b1; break; end
            end
            bus.ahbm_hready = 1'b1;
            tick(); tick();
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd%0d_timeout got=%0b exp=1", it, ok); end
            checks++; if (wr_a.size() - sb_w0 !== n) begin errors++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", it, wr_a.size() - sb_w0, n); end
            checks++; if (sb_errors(base) !== 0) begin errors++; $display("FAIL rnd%0d_scoreboard got=%0d exp=0", it, sb_errors(base)); end
            checks++; if (stall_bad - sb0 !== 0) begin errors++; $display("FAIL rnd%0d_stable got=%0d exp=0", it, stall_bad - sb0); end
            checks++; if (bad_trans - bt0 !== 0) begin errors++; $display("FAIL rnd%0d_htrans got=%0d exp=0", it, bad_trans - bt0); end
            checks++; if (bad_hwdata - bh0 !== 0) begin errors++; $display("FAIL rnd%0d_hwdata got=%0d exp=0", it, bad_hwdata - bh0); end
            if (wr_cyc.size() > 0) begin
                checks++; if (done_cyc !== wr_cyc[$] + 1) begin errors++; $display("FAIL rnd%0d_done_lat got=%0d exp=%0d", it, done_cyc, wr_cyc[$] + 1); end
            end
        end
        vmode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_start   = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_count   = '0;
        bus.ahbm_hready = 1'b1;
        bus.ahbm_hresp  = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_gapped();
        test_error();
        test_zero_and_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
